// File: rtl/dmem_responder.sv
// Data-memory responder for the core's mem_D port: fixed-latency 64-bit loads/stores
// against an internal word array, with misaligned/out-of-range accesses flagged as faults.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_cen_D,
  input  logic        mem_wen_D,
  input  logic [31:0] mem_addr_D,
  input  logic [63:0] mem_wdata_D,
  output logic [63:0] mem_rdata_D,
  output logic        mem_ready_D,
  output logic        mem_err_D,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_we;

  logic [63:0] mem_q [DEPTH];

  logic [31:0] offset;
  logic [31:0] idx;
  logic        fault;

  // Addresses below BASE_ADDR wrap to a huge offset and fall into the range fault.
  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset >> 3;
  assign fault  = (addr_q[2:0] != 3'b000) || (idx >= 32'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_cen_D) begin
          wen_d   = mem_wen_D;
          addr_d  = mem_addr_D;
          wdata_d = mem_wdata_D;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (fault) begin
            err_d = 1'b1;
          end else if (wen_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx[AW-1:0]];
          end
        end
      end
      RESP: begin
        // rdata/err fall back to their zero defaults on the way out.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[idx[AW-1:0]] <= wdata_q;
    end
  end

  assign mem_rdata_D = rdata_q;
  assign mem_err_D   = err_q;
  assign mem_ready_D = (state_q == RESP);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int unsigned DEP  = 256;
  localparam int unsigned LAT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_cen_D = 1'b0;
  logic        mem_wen_D = 1'b0;
  logic [31:0] mem_addr_D = '0;
  logic [63:0] mem_wdata_D = '0;
  logic [63:0] mem_rdata_D;
  logic        mem_ready_D;
  logic        mem_err_D;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] model [DEP];

  dmem_responder #(
    .BASE_ADDR(BASE),
    .DEPTH(DEP),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_cen_D(mem_cen_D),
    .mem_wen_D(mem_wen_D),
    .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D),
    .mem_rdata_D(mem_rdata_D),
    .mem_ready_D(mem_ready_D),
    .mem_err_D(mem_err_D),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 8 != 0) || (off / 8 >= DEP);
  endfunction

  // Expected load data (0 on fault or store) from the model before the access.
  function automatic logic [63:0] exp_rdata(input logic w, input logic [31:0] a);
    if (w || is_fault(a)) return 64'd0;
    return model[(a - BASE) / 8];
  endfunction

  function automatic logic [31:0] gen_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      6:       return BASE + 8 * $urandom_range(0, DEP - 1) + $urandom_range(1, 7);
      7:       return BASE + 8 * DEP + 8 * $urandom_range(0, 100);
      8:       return BASE - 8 * $urandom_range(1, 100);
      9:       return BASE + 8 * (DEP - 1);
      default: return BASE + 8 * $urandom_range(0, DEP - 1);
    endcase
  endfunction

  // Called #1 after an edge with the DUT idle; leaves the bench #1 after the edge ending RESP.
  task automatic run_txn(input string tag, input logic w, input logic [31:0] a, input logic [63:0] wd);
    logic [63:0] erd;
    logic        eerr;
    int unsigned n;
    erd  = exp_rdata(w, a);
    eerr = is_fault(a);
    mem_cen_D   = 1'b1;
    mem_wen_D   = w;
    mem_addr_D  = a;
    mem_wdata_D = wd;
    step();
    check_eq({tag, ".busy"}, 64'(busy), 64'd1);
    // Scramble inputs while waiting: the latched request must be used.
    mem_wen_D   = 1'($urandom);
    mem_addr_D  = $urandom;
    mem_wdata_D = {$urandom, $urandom};
    n = 0;
    while (!mem_ready_D && n < 40) begin
      step();
      n++;
    end
    check_eq({tag, ".lat"}, 64'(n), 64'(LAT));
    check_eq({tag, ".err"}, 64'(mem_err_D), 64'(eerr));
    check_eq({tag, ".rdata"}, mem_rdata_D, erd);
    if (w && !eerr) model[(a - BASE) / 8] = wd;
    mem_cen_D = 1'b0;
    step();
    check_eq({tag, ".ready_off"}, 64'(mem_ready_D), 64'd0);
    check_eq({tag, ".rdata_off"}, mem_rdata_D, 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [31:0] a, b;
    int unsigned n;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check_eq("rst.ready", 64'(mem_ready_D), 64'd0);
    check_eq("rst.err", 64'(mem_err_D), 64'd0);
    check_eq("rst.rdata", mem_rdata_D, 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    // Fill every word so later loads have known contents
    for (int unsigned i = 0; i < DEP; i++) begin
      run_txn("fill", 1'b1, BASE + 8 * i, {$urandom, $urandom});
    end

    // Directed: store/load round trip
    run_txn("st8", 1'b1, 32'h0001_0008, 64'hDEAD_BEEF_0123_4567);
    run_txn("ld8", 1'b0, 32'h0001_0008, 64'd0);
    check_eq("ld8.model", model[1], 64'hDEAD_BEEF_0123_4567);

    // Faults: misaligned, idx==DEPTH, below base; word 0 untouched
    run_txn("mis", 1'b0, 32'h0001_000C, 64'd0);
    run_txn("oor", 1'b1, 32'h0001_0800, 64'hFFFF_FFFF_FFFF_FFFF);
    run_txn("ld0", 1'b0, BASE, 64'd0);
    run_txn("below", 1'b0, 32'h0000_FFF8, 64'd0);
    run_txn("st_last", 1'b1, 32'h0001_07F8, 64'h0BAD_F00D_CAFE_1234);
    run_txn("ld_last", 1'b0, 32'h0001_07F8, 64'd0);

    // Reset during WAIT of a store: no ready, store dropped
    mem_cen_D   = 1'b1;
    mem_wen_D   = 1'b1;
    mem_addr_D  = 32'h0001_0010;
    mem_wdata_D = 64'h1;
    step();
    rst       = 1'b1;
    mem_cen_D = 1'b0;
    n = 0;
    for (int unsigned i = 0; i < LAT + 1; i++) begin
      step();
      if (mem_ready_D) n++;
    end
    check_eq("rstw.ready_seen", 64'(n), 64'd0);
    check_eq("rstw.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    run_txn("rstw.ld", 1'b0, 32'h0001_0010, 64'd0);

    // Back-to-back loads with mem_cen_D held high
    a = BASE + 8 * 5;
    b = BASE + 8 * 9;
    mem_cen_D  = 1'b1;
    mem_wen_D  = 1'b0;
    mem_addr_D = a;
    step();
    mem_addr_D = b;
    n = 0;
    while (!mem_ready_D && n < 40) begin
      step();
      n++;
    end
    check_eq("b2b.lat1", 64'(n), 64'(LAT));
    check_eq("b2b.rd1", mem_rdata_D, model[5]);
    n = 0;
    step();
    n++;
    while (!mem_ready_D && n < 40) begin
      step();
      n++;
    end
    mem_cen_D = 1'b0;
    check_eq("b2b.period", 64'(n), 64'(LAT + 2));
    check_eq("b2b.rd2", mem_rdata_D, model[9]);
    step();
    check_eq("b2b.idle", 64'(busy), 64'd0);

    // Randomized mix
    for (int unsigned i = 0; i < 200; i++) begin
      d = {$urandom, $urandom};
      run_txn("rnd", 1'($urandom), gen_addr(), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
